// File: rtl/diff_event_decoder.sv
// Edge-difference code receiver: decode, link-sync FSM,
// event FIFO with valid/ready drain and saturating stats.
//
// Ports:
//   clock_0, reset_0          clock, sync active-high reset
//   in_valid, in_code         sampled difference code
//   evt_ready                 consumer accepts head event
//   evt_valid/kind/seq        FIFO head event
//   sync_ok, overflow         link synced, sticky drop flag
//   cnt_a, cnt_b              kind-1 / kind-2 events pushed
//   err_cnt, drop_cnt         illegal codes / dropped events
module diff_event_decoder #(
  parameter int WIDTH    = 6,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 8,
  parameter int ERR_HOLD = 3
) (
  input  logic             clock_0,
  input  logic             reset_0,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_code,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [1:0]       evt_kind,
  output logic [CNT_W-1:0] evt_seq,
  output logic             sync_ok,
  output logic             overflow,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(ERR_HOLD + 1);

  typedef enum logic [1:0] {
    ST_UNSYNC,
    ST_SYNC,
    ST_ERR
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  logic is_idle;
  logic is_k1;
  logic is_k2;
  logic is_ill;

  always_comb begin
    is_idle = 1'b0;
    is_k1   = 1'b0;
    is_k2   = 1'b0;
    is_ill  = 1'b0;
    if (in_valid) begin
      unique case (1'b1)
        (in_code == WIDTH'(0)): is_idle = 1'b1;
        (in_code == WIDTH'(1)): is_k1   = 1'b1;
        (in_code == WIDTH'(2)): is_k2   = 1'b1;
        default:                is_ill  = 1'b1;
      endcase
    end
  end

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idle_q;
  logic [IW-1:0] idle_nxt;

  always_ff @(posedge clock_0) begin
    if (reset_0) begin
      state  <= ST_UNSYNC;
      idle_q <= '0;
    end else begin
      state  <= state_nxt;
      idle_q <= idle_nxt;
    end
  end

  // idle_q counts consecutive idles while in ST_ERR;
  // any non-idle code restarts the run.
  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_q;
    unique case (state)
      ST_UNSYNC: begin
        if (is_idle) begin
          state_nxt = ST_SYNC;
        end else if (is_ill) begin
          state_nxt = ST_ERR;
          idle_nxt  = '0;
        end
      end
      ST_SYNC: begin
        if (is_ill) begin
          state_nxt = ST_ERR;
          idle_nxt  = '0;
        end
      end
      ST_ERR: begin
        if (is_idle) begin
          if (idle_q == IW'(ERR_HOLD - 1)) begin
            state_nxt = ST_SYNC;
            idle_nxt  = '0;
          end else begin
            idle_nxt = idle_q + 1'b1;
          end
        end else if (is_k1 || is_k2 || is_ill) begin
          idle_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_UNSYNC;
        idle_nxt  = '0;
      end
    endcase
  end

  assign sync_ok = (state == ST_SYNC);

  logic [1:0]       kind_mem [DEPTH];
  logic [CNT_W-1:0] seq_mem  [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [OW-1:0]    occ;
  logic [CNT_W-1:0] seq_q;

  logic full;
  logic empty;
  logic pop;
  logic push_req;
  logic wr_en;
  logic drop;
  logic [1:0] wr_kind;

  assign full     = (occ == OW'(DEPTH));
  assign empty    = (occ == '0);
  assign pop      = !empty && evt_ready;
  assign push_req = sync_ok && (is_k1 || is_k2);
  // A pop frees a slot in the same edge, so
  // a full FIFO still accepts when draining.
  assign wr_en    = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign wr_kind  = is_k1 ? 2'd1 : 2'd2;

  always_ff @(posedge clock_0) begin
    if (wr_en) begin
      kind_mem[wr_ptr] <= wr_kind;
      seq_mem[wr_ptr]  <= seq_q;
    end
  end

  always_ff @(posedge clock_0) begin
    if (reset_0) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      seq_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        seq_q  <= seq_q + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_en, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign evt_valid = !empty;
  assign evt_kind  = empty ? 2'd0 : kind_mem[rd_ptr];
  assign evt_seq   = empty ? '0 : seq_mem[rd_ptr];

  always_ff @(posedge clock_0) begin
    if (reset_0) begin
      cnt_a    <= '0;
      cnt_b    <= '0;
      err_cnt  <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en && is_k1) begin
        cnt_a <= sat_inc(cnt_a);
      end
      if (wr_en && is_k2) begin
        cnt_b <= sat_inc(cnt_b);
      end
      if (is_ill) begin
        err_cnt <= sat_inc(err_cnt);
      end
      if (drop) begin
        drop_cnt <= sat_inc(drop_cnt);
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_diff_event_decoder.sv
// Self-checking bench for diff_event_decoder:
// directed scenarios plus random traffic vs a queue model.
module tb_diff_event_decoder;

  localparam int DEPTH    = 4;
  localparam int ERR_HOLD = 3;

  logic       clock_0;
  logic       reset_0;
  logic       in_valid;
  logic [5:0] in_code;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_kind;
  logic [7:0] evt_seq;
  logic       sync_ok;
  logic       overflow;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
  logic [7:0] err_cnt;
  logic [7:0] drop_cnt;

  diff_event_decoder #(
    .WIDTH(6), .DEPTH(DEPTH), .CNT_W(8), .ERR_HOLD(ERR_HOLD)
  ) dut (
    .clock_0(clock_0), .reset_0(reset_0),
    .in_valid(in_valid), .in_code(in_code),
    .evt_ready(evt_ready), .evt_valid(evt_valid),
    .evt_kind(evt_kind), .evt_seq(evt_seq),
    .sync_ok(sync_ok), .overflow(overflow),
    .cnt_a(cnt_a), .cnt_b(cnt_b),
    .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  initial clock_0 = 1'b0;
  always #5 clock_0 = ~clock_0;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int M_UNSYNC = 0;
  localparam int M_SYNC   = 1;
  localparam int M_ERR    = 2;

  logic [9:0] m_q[$];
  logic [7:0] m_seq, m_a, m_b, m_err, m_drop;
  logic       m_ovf;
  int         m_mode, m_idle;

  function automatic logic [7:0] inc_sat(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_seq = 0; m_a = 0; m_b = 0; m_err = 0; m_drop = 0;
    m_ovf = 0; m_mode = M_UNSYNC; m_idle = 0;
  endtask

  task automatic model_step(input logic v, input logic [5:0] c,
                            input logic r);
    bit pop, full, push;
    pop  = r && (m_q.size() != 0);
    full = (m_q.size() == DEPTH);
    push = v && (m_mode == M_SYNC) && (c == 1 || c == 2);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (full && !pop) begin
        m_drop = inc_sat(m_drop);
        m_ovf  = 1'b1;
      end else begin
        m_q.push_back({c[1:0], m_seq});
        m_seq = m_seq + 8'd1;
        if (c == 1) m_a = inc_sat(m_a);
        else        m_b = inc_sat(m_b);
      end
    end
    if (v) begin
      if (c > 2) m_err = inc_sat(m_err);
      if (m_mode == M_UNSYNC) begin
        if (c == 0) m_mode = M_SYNC;
        else if (c > 2) begin m_mode = M_ERR; m_idle = 0; end
      end else if (m_mode == M_SYNC) begin
        if (c > 2) begin m_mode = M_ERR; m_idle = 0; end
      end else begin
        if (c == 0) begin
          m_idle++;
          if (m_idle >= ERR_HOLD) begin
            m_mode = M_SYNC; m_idle = 0;
          end
        end else m_idle = 0;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] c,
                       input logic r);
    in_valid = v; in_code = c; evt_ready = r;
    @(posedge clock_0);
    model_step(v, c, r);
    @(negedge clock_0);
  endtask

  task automatic do_reset();
    reset_0 = 1'b1; in_valid = 0; in_code = 0; evt_ready = 0;
    @(posedge clock_0);
    model_reset();
    @(negedge clock_0);
    reset_0 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({evt_valid, sync_ok, overflow} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000",
               {evt_valid, sync_ok, overflow});
    end
    n_tests++;
    if ({cnt_a, cnt_b, err_cnt, drop_cnt} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cnts got %h want 0",
               {cnt_a, cnt_b, err_cnt, drop_cnt});
    end
  endtask

  task automatic test_unsync_ignore();
    drive(1, 2, 1);
    drive(1, 1, 1);
    n_tests++;
    if ({evt_valid, sync_ok} !== 2'b00) begin
      n_fail++;
      $display("FAIL unsync_flags got %b want 00",
               {evt_valid, sync_ok});
    end
    n_tests++;
    if ({cnt_a, cnt_b} !== 16'd0) begin
      n_fail++;
      $display("FAIL unsync_cnts got %h want 0", {cnt_a, cnt_b});
    end
  endtask

  task automatic test_sync_push();
    logic [5:0] codes[3];
    logic [1:0] kinds[3];
    codes = '{6'd1, 6'd2, 6'd2};
    kinds = '{2'd1, 2'd2, 2'd2};
    drive(1, 0, 1);
    n_tests++;
    if (sync_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_after_idle got %b want 1", sync_ok);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, codes[i], 1);
      n_tests++;
      if ({evt_valid, evt_kind, evt_seq} !== {1'b1, kinds[i], 8'(i)})
      begin
        n_fail++;
        $display("FAIL push_evt%0d got v%b k%0d s%0d want v1 k%0d s%0d",
                 i, evt_valid, evt_kind, evt_seq, kinds[i], i);
      end
    end
    drive(0, 0, 1);
    n_tests++;
    if ({evt_valid, cnt_a, cnt_b} !== {1'b0, 8'd1, 8'd2}) begin
      n_fail++;
      $display("FAIL push_end got v%b a%0d b%0d want v0 a1 b2",
               evt_valid, cnt_a, cnt_b);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    drive(1, 0, 0);
    for (int i = 0; i < 6; i++) drive(1, 1, 0);
    n_tests++;
    if ({evt_valid, overflow, drop_cnt, evt_seq} !==
        {1'b1, 1'b1, 8'd2, 8'd0}) begin
      n_fail++;
      $display("FAIL ovf_state got v%b o%b d%0d s%0d want v1 o1 d2 s0",
               evt_valid, overflow, drop_cnt, evt_seq);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({evt_valid, evt_kind, evt_seq} !== {1'b1, 2'd1, 8'(i)}) begin
        n_fail++;
        $display("FAIL drain%0d got v%b k%0d s%0d want v1 k1 s%0d",
                 i, evt_valid, evt_kind, evt_seq, i);
      end
      drive(0, 0, 1);
    end
    n_tests++;
    if ({evt_valid, overflow} !== 2'b01) begin
      n_fail++;
      $display("FAIL drain_end got v%b o%b want v0 o1",
               evt_valid, overflow);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    drive(1, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 0);
    drive(1, 2, 1);
    n_tests++;
    if ({drop_cnt, cnt_b, evt_seq} !== {8'd0, 8'd1, 8'd1}) begin
      n_fail++;
      $display("FAIL full_pop got d%0d b%0d s%0d want d0 b1 s1",
               drop_cnt, cnt_b, evt_seq);
    end
    for (int i = 1; i <= 4; i++) begin
      n_tests++;
      if ({evt_valid, evt_kind, evt_seq} !==
          {1'b1, (i == 4) ? 2'd2 : 2'd1, 8'(i)}) begin
        n_fail++;
        $display("FAIL full_drain%0d got v%b k%0d s%0d",
                 i, evt_valid, evt_kind, evt_seq);
      end
      drive(0, 0, 1);
    end
    n_tests++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_empty got %b want 0", evt_valid);
    end
  endtask

  task automatic test_err_recovery();
    logic [5:0] codes[6];
    logic       want[6];
    codes = '{6'd0, 6'd0, 6'd1, 6'd0, 6'd0, 6'd0};
    want  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    drive(1, 0, 1);
    drive(1, 5, 1);
    n_tests++;
    if ({sync_ok, err_cnt} !== {1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL err_enter got s%b e%0d want s0 e1",
               sync_ok, err_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, codes[i], 1);
      n_tests++;
      if (sync_ok !== want[i]) begin
        n_fail++;
        $display("FAIL err_rec%0d got %b want %b",
                 i, sync_ok, want[i]);
      end
    end
    n_tests++;
    if ({evt_valid, cnt_a} !== {1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL err_nopush got v%b a%0d want v0 a0",
               evt_valid, cnt_a);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 2, 0);
    drive(0, 0, 1);
    n_tests++;
    if ({evt_valid, overflow, m_q.size() == 3} !== 3'b111) begin
      n_fail++;
      $display("FAIL mid_pre got v%b o%b", evt_valid, overflow);
    end
    do_reset();
    n_tests++;
    if ({evt_valid, overflow, sync_ok, cnt_a, cnt_b, err_cnt,
         drop_cnt} !== 35'd0) begin
      n_fail++;
      $display("FAIL mid_reset got v%b o%b s%b b%0d d%0d want all 0",
               evt_valid, overflow, sync_ok, cnt_b, drop_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) drive(1, 7, 0);
    n_tests++;
    if (err_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_err got %0d want 255", err_cnt);
    end
    for (int i = 0; i < ERR_HOLD; i++) drive(1, 0, 0);
    for (int i = 0; i < 300; i++) drive(1, 1, 1);
    n_tests++;
    if ({cnt_a, evt_seq} !== {8'd255, m_q[0][7:0]}) begin
      n_fail++;
      $display("FAIL sat_a got a%0d s%0d want a255 s%0d",
               cnt_a, evt_seq, m_q[0][7:0]);
    end
    for (int i = 0; i < 300; i++) drive(1, 2, 0);
    n_tests++;
    if ({drop_cnt, cnt_b, overflow} !== {8'd255, 8'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_drop got d%0d b%0d o%b want d255 b3 o1",
               drop_cnt, cnt_b, overflow);
    end
  endtask

  task automatic test_random();
    logic       v, r;
    logic [5:0] c;
    int         k;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 9);
      if (k < 3)      c = 6'd0;
      else if (k < 6) c = 6'd1;
      else if (k < 9) c = 6'd2;
      else            c = 6'($urandom_range(3, 63));
      r = ($urandom_range(0, 2) == 0);
      drive(v, c, r);
      n_tests++;
      if ({evt_valid, sync_ok, overflow} !==
          {m_q.size() != 0, m_mode == M_SYNC, m_ovf}) begin
        n_fail++;
        $display("FAIL rnd_flags@%0d got %b want %b", i,
                 {evt_valid, sync_ok, overflow},
                 {m_q.size() != 0, m_mode == M_SYNC, m_ovf});
      end
      n_tests++;
      if ({cnt_a, cnt_b, err_cnt, drop_cnt} !==
          {m_a, m_b, m_err, m_drop}) begin
        n_fail++;
        $display("FAIL rnd_cnts@%0d got %h want %h", i,
                 {cnt_a, cnt_b, err_cnt, drop_cnt},
                 {m_a, m_b, m_err, m_drop});
      end
      if (m_q.size() != 0) begin
        n_tests++;
        if ({evt_kind, evt_seq} !== m_q[0]) begin
          n_fail++;
          $display("FAIL rnd_head@%0d got %h want %h", i,
                   {evt_kind, evt_seq}, m_q[0]);
        end
      end
    end
  endtask

  initial begin
    reset_0 = 1'b1; in_valid = 0; in_code = 0; evt_ready = 0;
    model_reset();
    @(negedge clock_0);
    test_reset();
    test_unsync_ignore();
    test_sync_push();
    test_overflow();
    test_full_pop();
    test_err_recovery();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
